// File: rtl/rx_pair_aligner_if.sv
// Byte-pair aligner bus: two demux byte lanes in, aligned word plus lock status out.
// The aligner sits on the slave side, and the upstream driver sits on the master side.
interface rx_pair_aligner_if;
  logic [7:0]  data_in0;
  logic        valid_in0;
  logic [7:0]  data_in1;
  logic        valid_in1;
  logic [15:0] word_out;
  logic        valid_out;
  logic        locked;
  logic        offset;
  logic        realign;

  modport master (
    output data_in0, valid_in0, data_in1, valid_in1,
    input  word_out, valid_out, locked, offset, realign
  );

  modport slave (
    input  data_in0, valid_in0, data_in1, valid_in1,
    output word_out, valid_out, locked, offset, realign
  );
endinterface

// File: rtl/rx_pair_aligner.sv
// Finds the COM symbol in either demux lane and emits 16-bit words with COM in the low byte.
// When COM lands in lane 1, each word pairs the previous lane-1 byte with the current lane-0 byte.
module rx_pair_aligner #(
  parameter logic [7:0]  COM_SYM    = 8'hBC,
  parameter int unsigned LOCK_COUNT = 2,
  parameter int unsigned LOSS_COUNT = 2
) (
  input logic              clk2,
  input logic              reset,
  rx_pair_aligner_if.slave bus
);

  typedef enum logic [1:0] {SEARCH, LOCKING, LOCKED} state_t;

  state_t      state_q, state_d;
  logic        offset_q, offset_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  miss_q, miss_d;
  logic [7:0]  hold_q, hold_d;
  logic        holdValid_q, holdValid_d;
  logic [15:0] word_q, word_d;
  logic        valid_q, valid_d;
  logic        realign_q, realign_d;

  logic       pairValid, hit0, hit1, hitAny, hitLane;
  logic [3:0] cntInc, missInc;

  assign pairValid = bus.valid_in0 & bus.valid_in1;
  assign hit0      = pairValid & (bus.data_in0 == COM_SYM);
  assign hit1      = pairValid & (bus.data_in1 == COM_SYM);
  assign hitAny    = hit0 | hit1;
  // Lane 0 wins when both lanes carry COM.
  assign hitLane   = ~hit0;
  assign cntInc    = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
  assign missInc   = (miss_q == 4'hF) ? miss_q : miss_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    cnt_d       = cnt_q;
    miss_d      = miss_q;
    hold_d      = pairValid ? bus.data_in1 : hold_q;
    holdValid_d = pairValid;
    word_d      = word_q;
    valid_d     = 1'b0;
    realign_d   = 1'b0;

    case (state_q)
      SEARCH: begin
        if (hitAny) begin
          offset_d = hitLane;
          cnt_d    = 4'd1;
          miss_d   = 4'd0;
          state_d  = (LOCK_COUNT <= 1) ? LOCKED : LOCKING;
        end
      end
      LOCKING: begin
        if (hitAny) begin
          if (hitLane == offset_q) begin
            cnt_d = cntInc;
            if (32'(cntInc) >= LOCK_COUNT) begin
              state_d = LOCKED;
              miss_d  = 4'd0;
            end
          end else begin
            offset_d = hitLane;
            cnt_d    = 4'd1;
          end
        end
      end
      LOCKED: begin
        if (hitAny) begin
          if (hitLane == offset_q) begin
            miss_d = 4'd0;
          end else if (32'(missInc) >= LOSS_COUNT) begin
            state_d   = SEARCH;
            cnt_d     = 4'd0;
            miss_d    = 4'd0;
            realign_d = 1'b1;
          end else begin
            miss_d = missInc;
          end
        end
      end
      default: state_d = SEARCH;
    endcase

    // On the locking cycle only an offset-0 pair is complete; offset 1 waits for the next lane-0 byte.
    if (pairValid && state_d == LOCKED) begin
      if (state_q == LOCKED) begin
        if (!offset_q) begin
          valid_d = 1'b1;
          word_d  = {bus.data_in1, bus.data_in0};
        end else if (holdValid_q) begin
          valid_d = 1'b1;
          word_d  = {bus.data_in0, hold_q};
        end
      end else if (!offset_d) begin
        valid_d = 1'b1;
        word_d  = {bus.data_in1, bus.data_in0};
      end
    end
  end

  always_ff @(posedge clk2) begin
    if (reset) begin
      state_q     <= SEARCH;
      offset_q    <= 1'b0;
      cnt_q       <= 4'd0;
      miss_q      <= 4'd0;
      hold_q      <= 8'h00;
      holdValid_q <= 1'b0;
      word_q      <= 16'h0000;
      valid_q     <= 1'b0;
      realign_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      offset_q    <= offset_d;
      cnt_q       <= cnt_d;
      miss_q      <= miss_d;
      hold_q      <= hold_d;
      holdValid_q <= holdValid_d;
      word_q      <= word_d;
      valid_q     <= valid_d;
      realign_q   <= realign_d;
    end
  end

  assign bus.word_out  = word_q;
  assign bus.valid_out = valid_q;
  assign bus.locked    = (state_q == LOCKED);
  assign bus.offset    = offset_q;
  assign bus.realign   = realign_q;

endmodule

// File: tb/tb_rx_pair_aligner.sv
// Table-driven bench for rx_pair_aligner: each row is one clk2 cycle of input and the outputs expected one cycle later.
module tb_rx_pair_aligner;
  logic clk2 = 1'b0;
  logic reset;

  rx_pair_aligner_if bus ();

  rx_pair_aligner #(
    .COM_SYM   (8'hBC),
    .LOCK_COUNT(2),
    .LOSS_COUNT(2)
  ) dut (
    .clk2 (clk2),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk2 = ~clk2;

  typedef struct {
    logic        rst;
    logic        v0;
    logic        v1;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic        expValid;
    logic        chkWord;
    logic [15:0] expWord;
    logic        expLocked;
    logic        expOffset;
    logic        expRealign;
  } vec_t;

  vec_t vecs[$];
  vec_t expQ[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t pr(logic [7:0] d0, logic [7:0] d1, logic ev, logic [15:0] ew,
                              logic el, logic eo, logic er);
    vec_t v;
    v = '{rst: 1'b0, v0: 1'b1, v1: 1'b1, d0: d0, d1: d1, expValid: ev, chkWord: ev,
          expWord: ew, expLocked: el, expOffset: eo, expRealign: er};
    return v;
  endfunction

  function automatic vec_t gap(logic v0, logic v1, logic [7:0] d0, logic [7:0] d1,
                               logic el, logic eo);
    vec_t v;
    v = '{rst: 1'b0, v0: v0, v1: v1, d0: d0, d1: d1, expValid: 1'b0, chkWord: 1'b0,
          expWord: 16'h0000, expLocked: el, expOffset: eo, expRealign: 1'b0};
    return v;
  endfunction

  function automatic vec_t rs();
    vec_t v;
    v = '{rst: 1'b1, v0: 1'b1, v1: 1'b1, d0: 8'hBC, d1: 8'hBC, expValid: 1'b0, chkWord: 1'b1,
          expWord: 16'h0000, expLocked: 1'b0, expOffset: 1'b0, expRealign: 1'b0};
    return v;
  endfunction

  task automatic compare(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk2);
    reset         = v.rst;
    bus.valid_in0 = v.v0;
    bus.valid_in1 = v.v1;
    bus.data_in0  = v.d0;
    bus.data_in1  = v.d1;
    expQ.push_back(v);
  endtask

  task automatic checkOutput(input int idx);
    vec_t e;
    @(posedge clk2);
    #1;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard row %0d: got empty queue expected one entry", idx);
    end else begin
      e = expQ.pop_front();
      compare("valid_out", idx, 16'(bus.valid_out), 16'(e.expValid));
      compare("locked",    idx, 16'(bus.locked),    16'(e.expLocked));
      compare("offset",    idx, 16'(bus.offset),    16'(e.expOffset));
      compare("realign",   idx, 16'(bus.realign),   16'(e.expRealign));
      if (e.chkWord) compare("word_out", idx, bus.word_out, e.expWord);
    end
  endtask

  initial begin
    int n;
    reset         = 1'b1;
    bus.valid_in0 = 1'b0;
    bus.valid_in1 = 1'b0;
    bus.data_in0  = 8'h00;
    bus.data_in1  = 8'h00;

    // Offset-0 lock, loss of lock, re-lock, and reset while streaming.
    vecs.push_back(rs());
    vecs.push_back(pr(8'hBC, 8'h11, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(pr(8'h22, 8'h33, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(pr(8'hBC, 8'h44, 1, 16'h44BC, 1, 0, 0));
    vecs.push_back(pr(8'h55, 8'h66, 1, 16'h6655, 1, 0, 0));
    vecs.push_back(pr(8'h00, 8'hBC, 1, 16'hBC00, 1, 0, 0));
    vecs.push_back(pr(8'h00, 8'hBC, 0, 16'h0000, 0, 0, 1));
    vecs.push_back(pr(8'hBC, 8'h01, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(pr(8'hBC, 8'h02, 1, 16'h02BC, 1, 0, 0));
    vecs.push_back(pr(8'h03, 8'h04, 1, 16'h0403, 1, 0, 0));
    vecs.push_back(rs());
    vecs.push_back(pr(8'hBC, 8'h06, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(pr(8'hBC, 8'h07, 1, 16'h07BC, 1, 0, 0));
    // Offset-1 lock, a lane-1 gap, then loss via lane-0 COM.
    vecs.push_back(rs());
    vecs.push_back(pr(8'h00, 8'hBC, 0, 16'h0000, 0, 1, 0));
    vecs.push_back(pr(8'hA1, 8'hB2, 0, 16'h0000, 0, 1, 0));
    vecs.push_back(pr(8'hC3, 8'hBC, 0, 16'h0000, 1, 1, 0));
    vecs.push_back(pr(8'hD4, 8'hE5, 1, 16'hD4BC, 1, 1, 0));
    vecs.push_back(pr(8'hF6, 8'h07, 1, 16'hF6E5, 1, 1, 0));
    vecs.push_back(gap(1, 0, 8'h08, 8'h00, 1, 1));
    vecs.push_back(pr(8'h09, 8'h0A, 0, 16'h0000, 1, 1, 0));
    vecs.push_back(pr(8'h0B, 8'h0C, 1, 16'h0B0A, 1, 1, 0));
    vecs.push_back(pr(8'hBC, 8'h0D, 1, 16'hBC0C, 1, 1, 0));
    vecs.push_back(pr(8'hBC, 8'h0E, 0, 16'h0000, 0, 1, 1));
    vecs.push_back(pr(8'h00, 8'h00, 0, 16'h0000, 0, 1, 0));
    // Offset change while locking; COM in both lanes; a same-offset hit clears the miss count.
    vecs.push_back(rs());
    vecs.push_back(pr(8'hBC, 8'h00, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(pr(8'h00, 8'hBC, 0, 16'h0000, 0, 1, 0));
    vecs.push_back(pr(8'h00, 8'hBC, 0, 16'h0000, 1, 1, 0));
    vecs.push_back(pr(8'hBC, 8'hBC, 1, 16'hBCBC, 1, 1, 0));
    vecs.push_back(pr(8'h11, 8'h22, 1, 16'h11BC, 1, 1, 0));
    vecs.push_back(pr(8'h33, 8'hBC, 1, 16'h3322, 1, 1, 0));
    vecs.push_back(pr(8'hBC, 8'h44, 1, 16'hBCBC, 1, 1, 0));
    vecs.push_back(pr(8'h55, 8'h66, 1, 16'h5544, 1, 1, 0));
    vecs.push_back(pr(8'hBC, 8'h77, 0, 16'h0000, 0, 1, 1));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(i);
    end

    // A pv=0 cycle during LOCKING must not reset the hit count; lock follows on the next hit.
    applyStimulus(rs());
    checkOutput(100);
    applyStimulus(pr(8'hBC, 8'h01, 0, 16'h0000, 0, 0, 0));
    checkOutput(101);
    applyStimulus(gap(0, 1, 8'hBC, 8'hBC, 0, 0));
    checkOutput(102);
    n = 0;
    do begin
      @(negedge clk2);
      reset         = 1'b0;
      bus.valid_in0 = 1'b1;
      bus.valid_in1 = 1'b1;
      bus.data_in0  = 8'hBC;
      bus.data_in1  = 8'h10 + 8'(n);
      @(posedge clk2);
      #1;
      n++;
    end while (!bus.locked && n < 8);
    compare("lockLatency", 103, 16'(n), 16'd1);
    compare("lockWord", 104, bus.word_out, 16'h10BC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
